// File: rtl/bitrev_frame_buffer.sv
// -----------------------------------------------------------------------------
// bitrev_frame_buffer
//
// Ping-pong reorder buffer for the FFT front end. Collects complex frames from
// a word stream (N real words followed by N imaginary words). It sign-extends
// each word and scales it to DATA_W. Each completed frame is replayed as N
// complex beats in bit-reversed or natural order over a valid/ready stream.
// While one bank is read out, the next frame is written into the other bank.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       input word (signed, IN_W bits)
//   in_valid      input word valid
//   in_ready      buffer can take in_data this cycle
//   mode_bitrev   1 = bit-reversed readout; sampled with word 0 of a frame
//   out_re/out_im output complex sample (DATA_W bits each)
//   out_idx       output beat index k (natural count)
//   out_valid     output beat valid
//   out_last      high on the final beat of a frame
//   out_ready     downstream accepts the beat
//   ovf_o         sticky: a word was offered while in_ready was low
// -----------------------------------------------------------------------------
module bitrev_frame_buffer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IN_W       = 8,
    parameter int unsigned FRAC_SHIFT = 6,
    parameter int unsigned LOG2N      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode_bitrev,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              ovf_o
);

    localparam int unsigned       N    = 2 ** LOG2N;
    localparam logic [LOG2N-1:0]  LAST = LOG2N'(N - 1);

    // Write FSM states
    localparam logic W_RE = 1'b0;
    localparam logic W_IM = 1'b1;

    // Read FSM states
    localparam logic R_IDLE   = 1'b0;
    localparam logic R_STREAM = 1'b1;

    // Pure wiring permutation: bit i of the result is bit LOG2N-1-i of k.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = k[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Storage: two banks of real and imaginary samples. No reset needed.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] re_mem [2][N];
    logic [DATA_W-1:0] im_mem [2][N];

    // Bank bookkeeping
    logic [1:0] full_q, full_d;
    logic [1:0] mode_q;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       ovf_q;

    // Write side
    logic             wr_state_q, wr_state_d;
    logic [LOG2N-1:0] wr_ptr_q, wr_ptr_d;
    logic             wr_accept;
    logic             wr_done;
    logic [DATA_W-1:0] in_ext;
    logic [DATA_W-1:0] in_word;

    // Read side
    logic              rd_state_q, rd_state_d;
    logic [LOG2N-1:0]  k_q, k_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q;
    logic [DATA_W-1:0] out_re_q, out_im_q;
    logic              load_en;
    logic              load_bank;
    logic [LOG2N-1:0]  load_k;
    logic [LOG2N-1:0]  load_addr;
    logic              rd_release;
    logic              go_idle;

    // -------------------------------------------------------------------------
    // Input conversion and handshake
    // -------------------------------------------------------------------------
    // The sized cast of a signed operand sign-extends to DATA_W.
    assign in_ext   = DATA_W'($signed(in_data));
    assign in_word  = in_ext << FRAC_SHIFT;

    assign in_ready  = !full_q[wr_bank_q];
    assign wr_accept = in_valid && in_ready;
    assign wr_done   = wr_accept && (wr_state_q == W_IM) && (wr_ptr_q == LAST);

    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        if (wr_accept) begin
            if (wr_ptr_q == LAST) begin
                wr_ptr_d = '0;
                if (wr_state_q == W_RE) begin
                    wr_state_d = W_IM;
                end else begin
                    wr_state_d = W_RE;
                    wr_bank_d  = ~wr_bank_q;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_RE;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            mode_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_bank_q  <= wr_bank_d;
            // Readout order is fixed per frame by the mode seen on word 0.
            if (wr_accept && (wr_state_q == W_RE) && (wr_ptr_q == '0)) begin
                mode_q[wr_bank_q] <= mode_bitrev;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (wr_state_q == W_RE) begin
                re_mem[wr_bank_q][wr_ptr_q] <= in_word;
            end else begin
                im_mem[wr_bank_q][wr_ptr_q] <= in_word;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM
    // -------------------------------------------------------------------------
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        load_en     = 1'b0;
        load_bank   = rd_bank_q;
        load_k      = '0;
        rd_release  = 1'b0;
        go_idle     = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load_en     = 1'b1;
                    rd_state_d  = R_STREAM;
                    k_d         = '0;
                    out_valid_d = 1'b1;
                end
            end
            R_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (k_q == LAST) begin
                        rd_release = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        // Other bank already waiting: chain straight into its
                        // beat 0 so there is no idle cycle between frames.
                        if (full_q[~rd_bank_q]) begin
                            load_en   = 1'b1;
                            load_bank = ~rd_bank_q;
                            k_d       = '0;
                        end else begin
                            go_idle     = 1'b1;
                            rd_state_d  = R_IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        load_en = 1'b1;
                        load_k  = k_q + 1'b1;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    assign load_addr = mode_q[load_bank] ? bitrev(load_k) : load_k;

    // Release and write completion always target different banks (a bank being
    // written is not full, a bank being read is), so both updates can apply.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_release) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            rd_state_q  <= R_IDLE;
            rd_bank_q   <= 1'b0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_bank_q   <= rd_bank_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            if (load_en) begin
                out_re_q   <= re_mem[load_bank][load_addr];
                out_im_q   <= im_mem[load_bank][load_addr];
                out_last_q <= (load_k == LAST);
            end else if (go_idle) begin
                out_last_q <= 1'b0;
            end
            if (in_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = k_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_bitrev_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_bitrev_frame_buffer
//
// Self-checking bench for bitrev_frame_buffer. Expected output beats are
// pushed to a scoreboard queue when a frame is sent; a negedge monitor pops
// and compares each accepted beat. Scenario tasks add their own checks for
// latency, boundaries, backpressure stability, overflow and reset.
// -----------------------------------------------------------------------------
module tb_bitrev_frame_buffer;

    localparam int DATA_W     = 32;
    localparam int IN_W       = 8;
    localparam int FRAC_SHIFT = 6;
    localparam int LOG2N      = 4;
    localparam int N          = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mode_bitrev = 1'b0;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [LOG2N-1:0]  out_idx;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              ovf_o;

    bitrev_frame_buffer #(
        .DATA_W     (DATA_W),
        .IN_W       (IN_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .LOG2N      (LOG2N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode_bitrev (mode_bitrev),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    beat_t      sb_q[$];
    beat_t      mon_exp;
    int         n_checks = 0;
    int         n_fail = 0;
    int         beats_seen = 0;
    logic [7:0] fr_re [N];
    logic [7:0] fr_im [N];

    // ---------------------------------------------------------------- model
    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r | (((k >> i) & 1) << (LOG2N - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [31:0] scale(input logic [7:0] b);
        int v;
        v = int'($signed(b)) * 64;
        return 32'(v);
    endfunction

    task automatic push_expected(input logic m);
        beat_t b;
        int    a;
        for (int k = 0; k < N; k++) begin
            a      = m ? brev(k) : k;
            b.re   = scale(fr_re[a]);
            b.im   = scale(fr_im[a]);
            b.idx  = 4'(k);
            b.last = (k == N - 1);
            sb_q.push_back(b);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            beats_seen++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat got idx=%0d re=%h required no beat",
                         out_idx, out_re);
            end else begin
                mon_exp = sb_q.pop_front();
                if (out_re !== mon_exp.re || out_im !== mon_exp.im ||
                    out_idx !== mon_exp.idx || out_last !== mon_exp.last) begin
                    n_fail++;
                    $display("FAIL beat got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d last=%b",
                             out_re, out_im, out_idx, out_last,
                             mon_exp.re, mon_exp.im, mon_exp.idx, mon_exp.last);
                end
            end
            n_checks++;
            if (out_re[5:0] !== 6'd0 || out_im[5:0] !== 6'd0) begin
                n_fail++;
                $display("FAIL low_bits got re=%h im=%h required low 6 bits 0", out_re, out_im);
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic send_word(input logic [7:0] b, input logic m);
        int w = 0;
        in_valid = 1'b0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout got in_ready=0 required 1");
        end
        in_data     = b;
        mode_bitrev = m;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic m);
        push_expected(m);
        for (int i = 0; i < N; i++) send_word(fr_re[i], m);
        for (int i = 0; i < N; i++) send_word(fr_im[i], m);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 600) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain got pending=%0d out_valid=%b required pending=0 out_valid=0",
                     sb_q.size(), out_valid);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 8'(i);
            fr_im[i] = 8'(8'h80 + i);
        end
    endtask

    // ----------------------------------------------------------- scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_re !== '0 || out_im !== '0 || out_idx !== '0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got re=%h im=%h idx=%0d v=%b l=%b ovf=%b required all 0",
                     out_re, out_im, out_idx, out_valid, out_last, ovf_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got in_ready=%b out_valid=%b required 1 0",
                     in_ready, out_valid);
        end
    endtask

    // Shared first-beat checks for the ramp frame in bit-reversed mode.
    task automatic test_bitrev();
        load_ramp();
        out_ready = 1'b1;
        send_frame(1'b1);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bitrev_latency_early got out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_re !== 32'h0 || out_im !== 32'hFFFFE000 ||
            out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL bitrev_beat0 got v=%b re=%h im=%h idx=%0d required 1 00000000 ffffe000 0",
                     out_valid, out_re, out_im, out_idx);
        end
        @(negedge clk);
        n_checks++;
        if (out_re !== 32'h200 || out_im !== 32'hFFFFE200 || out_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL bitrev_beat1 got re=%h im=%h idx=%0d required 00000200 ffffe200 1",
                     out_re, out_im, out_idx);
        end
        repeat (14) @(negedge clk);
        n_checks++;
        if (out_re !== 32'h3C0 || out_last !== 1'b1 || out_idx !== 4'd15) begin
            n_fail++;
            $display("FAIL bitrev_beat15 got re=%h last=%b idx=%0d required 000003c0 1 15",
                     out_re, out_last, out_idx);
        end
        wait_drain();
    endtask

    task automatic test_natural();
        load_ramp();
        out_ready = 1'b1;
        send_frame(1'b0);
        repeat (2) @(negedge clk);
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_re !== 32'h140 || out_idx !== 4'd5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL natural_beat5 got re=%h idx=%0d v=%b required 00000140 5 1",
                     out_re, out_idx, out_valid);
        end
        wait_drain();
    endtask

    task automatic test_extremes();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 8'($urandom_range(0, 255));
            fr_im[i] = 8'($urandom_range(0, 255));
        end
        fr_re[0] = 8'h7F; fr_im[0] = 8'h80;
        fr_re[1] = 8'h80; fr_im[1] = 8'h7F;
        fr_re[2] = 8'hFF; fr_im[2] = 8'h01;
        out_ready = 1'b1;
        send_frame(1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_re !== 32'h00001FC0 || out_im !== 32'hFFFFE000) begin
            n_fail++;
            $display("FAIL extreme_beat0 got re=%h im=%h required 00001fc0 ffffe000",
                     out_re, out_im);
        end
        @(negedge clk);
        n_checks++;
        if (out_re !== 32'hFFFFE000 || out_im !== 32'h00001FC0) begin
            n_fail++;
            $display("FAIL extreme_beat1 got re=%h im=%h required ffffe000 00001fc0",
                     out_re, out_im);
        end
        @(negedge clk);
        n_checks++;
        if (out_re !== 32'hFFFFFFC0 || out_im !== 32'h00000040) begin
            n_fail++;
            $display("FAIL extreme_beat2 got re=%h im=%h required ffffffc0 00000040",
                     out_re, out_im);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int          b0;
        int          w;
        logic        done;
        logic        stall;
        logic [31:0] h_re, h_im;
        logic [3:0]  h_idx;
        logic        h_last;
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 8'($urandom_range(0, 255));
            fr_im[i] = 8'($urandom_range(0, 255));
        end
        b0    = beats_seen;
        done  = 1'b0;
        stall = 1'b0;
        w     = 0;
        fork
            send_frame(1'b1);
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                while (beats_seen - b0 < N && w < 1500) begin
                    @(negedge clk);
                    w++;
                    if (stall) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || out_re !== h_re || out_im !== h_im ||
                            out_idx !== h_idx || out_last !== h_last) begin
                            n_fail++;
                            $display("FAIL bp_stable got v=%b re=%h im=%h idx=%0d l=%b required 1 %h %h %0d %b",
                                     out_valid, out_re, out_im, out_idx, out_last,
                                     h_re, h_im, h_idx, h_last);
                        end
                    end
                    stall  = out_valid && !out_ready;
                    h_re   = out_re;
                    h_im   = out_im;
                    h_idx  = out_idx;
                    h_last = out_last;
                end
                done = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();
        repeat (5) @(negedge clk);
        n_checks++;
        if (beats_seen - b0 !== N) begin
            n_fail++;
            $display("FAIL bp_beat_count got %0d required %0d", beats_seen - b0, N);
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        out_ready = 1'b0;
        load_ramp();
        send_frame(1'b1);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 8'(8'h40 + i);
            fr_im[i] = 8'(8'hC0 - i);
        end
        send_frame(1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || ovf_o !== 1'b0 || out_valid !== 1'b1 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_full got in_ready=%b ovf=%b v=%b idx=%0d required 0 0 1 0",
                     in_ready, ovf_o, out_valid, out_idx);
        end
        in_data  = 8'hAA;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ovf got ovf_o=%b required 1", ovf_o);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_re !== 32'h0) begin
            n_fail++;
            $display("FAIL b2b_hold got v=%b idx=%0d re=%h required 1 0 00000000",
                     out_valid, out_idx, out_re);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1) gaps++;
            if (i == N - 1) begin
                n_checks++;
                if (in_ready !== 1'b0 || out_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_pre_release got in_ready=%b last=%b required 0 1",
                             in_ready, out_last);
                end
            end
            if (i == N) begin
                n_checks++;
                if (in_ready !== 1'b1 || out_idx !== 4'd0 || out_re !== 32'h1000) begin
                    n_fail++;
                    $display("FAIL b2b_post_release got in_ready=%b idx=%0d re=%h required 1 0 00001000",
                             in_ready, out_idx, out_re);
                end
            end
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL b2b_bubbles got %0d required 0", gaps);
        end
        wait_drain();
        // The dropped word must not have shifted the next frame.
        load_ramp();
        send_frame(1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        load_ramp();
        for (int i = 0; i < 10; i++) send_word(fr_re[i], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ovf_o !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b ovf=%b in_ready=%b required 0 0 1",
                     out_valid, ovf_o, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || ovf_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_reset_idle got %0d bad cycles required 0", bad);
        end
        test_bitrev();
    endtask

    initial begin
        test_reset();
        test_bitrev();
        test_natural();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bitrev_frame_buffer.md
Name: bitrev_frame_buffer

Overview:
Parametrised reorder buffer for the FFT front end. It collects complex frames from a byte/word stream: N real words, then N imaginary words. Each word is sign-extended and scaled to the FFT data width. Frames are replayed to the FFT core in bit-reversed or natural order through a valid/ready stream. Two ping-pong banks let frame k+1 be written while frame k is read out; the byte source (UART RX or other) sits outside the block.

Parameters:
DATA_W, 32, output sample width; must satisfy DATA_W >= IN_W+FRAC_SHIFT
IN_W, 8, input word width (signed two's complement)
FRAC_SHIFT, 6, left shift applied after sign extension
LOG2N, 4, log2 of frame length; N = 2**LOG2N

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_data  in  IN_W  input word
in_valid  in  1  input word valid
in_ready  out  1  block can accept in_data this cycle
mode_bitrev  in  1  1 = bit-reversed readout, 0 = natural; sampled with the first word of each frame
out_re  out  DATA_W  real sample
out_im  out  DATA_W  imaginary sample
out_idx  out  LOG2N  output beat index k (natural count 0..N-1)
out_valid  out  1  output beat valid
out_last  out  1  high on beat k = N-1
out_ready  in  1  downstream accepts beat
ovf_o  out  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset is asynchronous, active-low, clock clk. It sets every output to 0: out_re, out_im, out_idx, out_valid, out_last, ovf_o. It clears both bank-full flags, sets wr_bank=0 and rd_bank=0, and puts both FSMs in their first state. A partial frame is discarded. Memory contents are don't-care.
- Input handshake: a word is accepted when in_valid && in_ready. in_ready = !full[wr_bank], combinational from registered state.
- Word conversion: stored = sign_extend(in_data, DATA_W-FRAC_SHIFT) << FRAC_SHIFT; low FRAC_SHIFT bits are 0.
- Write FSM states:
  - W_RE: words 0..N-1 go to re[wr_bank][wr_ptr]. On word 0, latch mode_bitrev into mode[wr_bank].
  - W_IM: words N..2N-1 go to im[wr_bank][wr_ptr-N].
  - After word 2N-1: set full[wr_bank], toggle wr_bank, return to W_RE with wr_ptr=0.
  - If the new wr_bank is still full, in_ready stays low until the read side releases it.
- Read FSM states:
  - R_IDLE: when full[rd_bank], go to R_STREAM with k=0 and load beat 0 (out_valid=1).
  - R_STREAM: beat k presents re/im[rd_bank][a], where a = bitrev_LOG2N(k) if mode[rd_bank] else k; out_idx=k; out_last=(k==N-1).
  - A beat advances only when out_valid && out_ready. While out_ready=0, all out_* are held stable.
  - On the handshake of the last beat: clear full[rd_bank], toggle rd_bank. Go to R_IDLE with out_valid=0 next cycle, unless the other bank is already full, in which case beat 0 of that bank loads directly (no bubble).
- Latency: the final input handshake at edge T sets full. out_valid rises at edge T+1. Sustained throughput is 1 output beat/cycle; input is 1 word/cycle. Because 2N writes exceed N reads, continuous input never stalls while out_ready=1.
- Simultaneous events:
  - Release of a bank and write completion on the other bank in the same cycle are both honoured.
  - When the read side releases the bank that is the current wr_bank, in_ready rises the cycle after the release.
- Overflow: ovf_o is set when in_valid && !in_ready. It is cleared only by reset. The offered word is dropped and wr_ptr does not change.
- Reset mid-operation (either phase): all state is aborted immediately. The first frame after reset starts at word 0 in bank 0.
- The bit reversal is a pure wiring permutation of k; no arithmetic is involved.

Test Plan:
1. LOG2N=4, mode_bitrev=1, out_ready=1, re bytes 0x00..0x0F, im bytes 0x80..0x8F. Expected readout:
   - k=0: out_re=0x00000000, out_im=0xFFFFE000.
   - k=1: out_re=0x00000200 (addr 8), out_im=0xFFFFE200.
   - k=15: out_re=0x000003C0, out_last=1.
   - out_valid rises 1 edge after the 32nd handshake.
2. Same data, mode_bitrev=0 -> out_re[k]=k<<6 for k=0..15, out_idx=k.
3. Extremes: byte 0x7F -> 0x00001FC0; byte 0x80 -> 0xFFFFE000; low 6 bits always 0.
4. Backpressure: out_ready pseudo-random at 50% -> out_* stable whenever out_ready=0; exactly 16 beats in bit-reversed order; no duplicates or losses.
5. Streaming with out_ready=0: after 2 full frames, in_ready=0; an extra in_valid sets ovf_o=1. Then raise out_ready -> both frames emerge in order with no bubble between them, and in_ready returns 1 the cycle after bank 0 is released.
6. Reset after 10 input words -> out_valid stays 0 and ovf_o=0. A fresh 32-word frame then yields scenario 1's exact output.
